// File: rtl/lfsr_prpg.sv
// BIST pattern generator / signature register: ring rotate, Fibonacci LFSR,
// MISR compaction and serial scan shift over one WIDTH-bit register.
module lfsr_prpg #(
  parameter int unsigned WIDTH   = 8,
  parameter logic [31:0] TAPS    = 32'h0000_00B8,
  parameter logic [31:0] SEED    = 32'h0000_0001,
  parameter int unsigned NUM_PAT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             scan_in,
  output logic [WIDTH-1:0] out,
  output logic             scan_out,
  output logic             done,
  output logic             lockup
);

  localparam int unsigned      CW       = $clog2(NUM_PAT + 1);
  localparam logic [WIDTH-1:0] TAPS_W   = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W   = SEED[WIDTH-1:0];
  localparam logic [CW-1:0]    LAST_CNT = CW'(NUM_PAT - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    MODE_RING = 2'b00,
    MODE_LFSR = 2'b01,
    MODE_MISR = 2'b10,
    MODE_SCAN = 2'b11
  } mode_e;

  // XOR-reduction of the tapped state bits.
  function automatic logic feedback(input logic [WIDTH-1:0] state);
    return ^(state & TAPS_W);
  endfunction

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] state,
                                               input logic             bit_in);
    return {state[WIDTH-2:0], bit_in};
  endfunction

  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             lockup_q, lockup_d;
  mode_e            mode_s;

  assign mode_s = mode_e'(mode);

  // Next-state: load beats advance; advancing stops once the pattern budget is spent.
  always_comb begin
    out_d    = out_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    lockup_d = 1'b0;
    if (load) begin
      out_d  = seed_in;
      cnt_d  = {CW{1'b0}};
      done_d = 1'b0;
    end else if (enb && !done_q) begin
      cnt_d  = cnt_q + CNT_ONE;
      done_d = (cnt_q == LAST_CNT);
      case (mode_s)
        MODE_RING: out_d = shift_in(out_q, out_q[WIDTH-1]);
        MODE_LFSR: begin
          // The all-zero state is a fixed point of the LFSR, so re-seed it.
          if (out_q == ALL_ZERO) begin
            out_d    = SEED_W;
            lockup_d = 1'b1;
          end else begin
            out_d    = shift_in(out_q, feedback(out_q));
          end
        end
        MODE_MISR: out_d = shift_in(out_q, feedback(out_q)) ^ data_in;
        MODE_SCAN: out_d = shift_in(out_q, scan_in);
        default:   out_d = out_q;
      endcase
    end else begin
      out_d = out_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q    <= SEED_W;
      cnt_q    <= {CW{1'b0}};
      done_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      lockup_q <= lockup_d;
    end
  end

  assign out      = out_q;
  assign scan_out = out_q[WIDTH-1];
  assign done     = done_q;
  assign lockup   = lockup_q;

endmodule

// File: tb/tb_lfsr_prpg.sv
// Directed bench for lfsr_prpg: a NUM_PAT=255 instance (dut_a) and a
// NUM_PAT=1000 instance (dut_b) share stimulus; dut_b shows the full period.
module tb_lfsr_prpg;

  logic       clk = 1'b0;
  logic       reset, enb, load, scan_in;
  logic [7:0] seed_in, data_in;
  logic [1:0] mode;
  logic [7:0] out_a, out_b;
  logic       scan_out_a, scan_out_b, done_a, done_b, lockup_a, lockup_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfsr_prpg #(.WIDTH(8), .TAPS(32'h0000_00B8), .SEED(32'h0000_0001), .NUM_PAT(255)) dut_a (
    .clk(clk), .reset(reset), .enb(enb), .load(load), .seed_in(seed_in), .mode(mode),
    .data_in(data_in), .scan_in(scan_in), .out(out_a), .scan_out(scan_out_a),
    .done(done_a), .lockup(lockup_a));

  lfsr_prpg #(.WIDTH(8), .TAPS(32'h0000_00B8), .SEED(32'h0000_0001), .NUM_PAT(1000)) dut_b (
    .clk(clk), .reset(reset), .enb(enb), .load(load), .seed_in(seed_in), .mode(mode),
    .data_in(data_in), .scan_in(scan_in), .out(out_b), .scan_out(scan_out_b),
    .done(done_b), .lockup(lockup_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]   ring_exp [8];
    logic [7:0]   lfsr_exp [5];
    logic [255:0] seen;
    logic [7:0]   scan_bits;
    int           bad;

    ring_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    lfsr_exp = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    scan_bits = 8'b1011_0010;

    reset = 1'b0; enb = 1'b0; load = 1'b0; scan_in = 1'b0;
    seed_in = 8'h00; data_in = 8'h00; mode = 2'b00;

    // Reset state
    tick(); tick();
    check("reset_out", {24'h0, out_a}, 32'h01);
    check("reset_done", {31'h0, done_a}, 32'h0);
    check("reset_lockup", {31'h0, lockup_a}, 32'h0);
    check("reset_scan_out", {31'h0, scan_out_a}, 32'h0);

    // Ring rotate
    reset = 1'b1; mode = 2'b00; enb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("ring_out", {24'h0, out_a}, {24'h0, ring_exp[i]});
      check("ring_scan_out", {31'h0, scan_out_a}, {31'h0, ring_exp[i] == 8'h80});
    end

    // LFSR first steps
    reset = 1'b0; enb = 1'b0; tick();
    reset = 1'b1; mode = 2'b01; enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("lfsr_seq", {24'h0, out_a}, {24'h0, lfsr_exp[i]});
    end

    // Full period on dut_b; terminator on dut_a
    reset = 1'b0; tick();
    reset = 1'b1;
    seen = '0;
    bad = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (out_b == 8'h00 || seen[out_b]) bad++;
      seen[out_b] = 1'b1;
      if (i == 254) check("done_before_last", {31'h0, done_a}, 32'h0);
    end
    check("period_distinct_nonzero", bad, 0);
    check("period_out_b", {24'h0, out_b}, 32'h01);
    check("period_done_b", {31'h0, done_b}, 32'h0);
    check("term_done", {31'h0, done_a}, 32'h1);
    check("term_out", {24'h0, out_a}, 32'h01);
    tick(); tick();
    check("frozen_out", {24'h0, out_a}, 32'h01);
    check("frozen_done", {31'h0, done_a}, 32'h1);
    check("b_keeps_running", {24'h0, out_b}, 32'h04);

    load = 1'b1; seed_in = 8'h5A; tick();
    check("reload_out", {24'h0, out_a}, 32'h5A);
    check("reload_done", {31'h0, done_a}, 32'h0);
    load = 1'b0; tick();
    check("resume_out", {24'h0, out_a}, 32'hB4);

    // Lockup recovery
    load = 1'b1; seed_in = 8'h00; enb = 1'b0; tick();
    check("zero_loaded", {24'h0, out_a}, 32'h00);
    check("no_lockup_on_load", {31'h0, lockup_a}, 32'h0);
    load = 1'b0; enb = 1'b1; tick();
    check("lockup_out", {24'h0, out_a}, 32'h01);
    check("lockup_pulse", {31'h0, lockup_a}, 32'h1);
    tick();
    check("after_lockup_out", {24'h0, out_a}, 32'h02);
    check("lockup_one_cycle", {31'h0, lockup_a}, 32'h0);
    enb = 1'b0; tick();
    check("hold_out", {24'h0, out_a}, 32'h02);

    // MISR, including reaching all-zero without recovery
    load = 1'b1; seed_in = 8'h01; tick();
    load = 1'b0; mode = 2'b10; data_in = 8'hFF; enb = 1'b1; tick();
    check("misr_out", {24'h0, out_a}, 32'hFD);
    data_in = 8'hFA; tick();
    check("misr_zero", {24'h0, out_a}, 32'h00);
    data_in = 8'h00; tick();
    check("misr_zero_stays", {24'h0, out_a}, 32'h00);
    check("misr_no_lockup", {31'h0, lockup_a}, 32'h0);

    // Priority
    load = 1'b1; seed_in = 8'h3C; enb = 1'b1; tick();
    check("load_beats_enb", {24'h0, out_a}, 32'h3C);
    reset = 1'b0; seed_in = 8'h77; tick();
    check("reset_beats_load", {24'h0, out_a}, 32'h01);
    reset = 1'b1;

    // Scan shift
    load = 1'b1; seed_in = 8'h00; enb = 1'b0; tick();
    load = 1'b0; mode = 2'b11; enb = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      scan_in = scan_bits[i];
      tick();
    end
    check("scan_out_reg", {24'h0, out_a}, 32'hB2);
    check("scan_out_pin", {31'h0, scan_out_a}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_prpg.md
# lfsr_prpg

Parametrised pattern generator and signature register for on-chip BIST, the next generation of the fixed 5-bit ring shifter. One register of WIDTH bits runs in one of four modes: ring rotate, maximal-length Fibonacci LFSR (PRPG), MISR signature compaction, or serial scan shift. It adds seed load, all-zero lockup recovery and a pattern-count terminator. It sits between the BIST controller (mode/enb/load/data) and the scan chains or CUT inputs; out/done feed back to the controller.

## Interface
- WIDTH, 8, register width; legal range 4..32.
- TAPS, 8'hB8, WIDTH-bit feedback mask; bit i set means out[i] enters the feedback XOR. The default is x^8+x^6+x^5+x^4+1.
- SEED, 1, WIDTH-bit reset and lockup-recovery value; must be nonzero.
- NUM_PAT, 255, number of advancing cycles before done; ≥1. CW = $clog2(NUM_PAT+1).
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset, sampled on rising clk.
- enb  input  1  advance enable.
- load  input  1  parallel seed load; also clears the pattern count and done.
- seed_in  input  WIDTH  value loaded when load=1.
- mode  input  2  00 ring, 01 LFSR, 10 MISR, 11 scan shift.
- data_in  input  WIDTH  MISR compaction input (mode 10 only).
- scan_in  input  1  serial input (mode 11 only).
- out  output  WIDTH  register state.
- scan_out  output  1  out[WIDTH-1], combinational from the register.
- done  output  1  sticky; high once NUM_PAT advances have completed.
- lockup  output  1  one-cycle pulse on lockup recovery.

## Operation
- Feedback fb = ^(out & TAPS).
- Priority per clock edge: reset, then load, then (enb & ~done), then hold.
- reset=0: out=SEED, count=0, done=0, lockup=0.
- load=1: out=seed_in, count=0, done=0, lockup=0. Load wins over enb in the same cycle. It is legal while done=1.
- Advance, where the next state depends on mode:
  - 00 ring: {out[W-2:0], out[W-1]}. All-zero stays all-zero; there is no recovery.
  - 01 LFSR: {out[W-2:0], fb}. If out==0, the next state is SEED and lockup=1 for that cycle. Otherwise lockup=0.
  - 10 MISR: {out[W-2:0], fb} ^ data_in. All-zero is a legal state here.
  - 11 scan: {out[W-2:0], scan_in}.
- Pattern count:
  - The count increments on every advance, including a lockup-recovery advance.
  - When an advance brings the count to NUM_PAT, done=1 on the same edge.
  - While done=1, enb is ignored: out and count are frozen.
- Mode may change between any two cycles. The new mode applies to the next advance, and the count is not reset.
- lockup is 0 in every cycle that is not an LFSR-mode recovery advance.
- Arithmetic:
  - All XOR logic is WIDTH-wide.
  - TAPS and SEED are truncated or zero-extended to WIDTH.
  - The count is a CW-bit unsigned value and never wraps: it is bounded by done.

## Timing
- All outputs are registered except scan_out, which is a wire from out[W-1].
- Latency is 1 cycle: the effect of load, enb or reset is visible on out, done and lockup after the next rising edge.
- Reset is synchronous. Deasserting reset mid-pattern restarts from SEED with count=0.
- Asserting reset during load or enb: reset wins.
- done rises on the edge of the NUM_PAT-th advance. It falls only on load or reset.
- enb=0: all state holds, and lockup=0.

## Test plan
- Ring mode, WIDTH=8 defaults:
  - Reset, then mode=00, enb=1 for 8 cycles -> out goes 0x01, 0x02, 0x04, …, 0x80, 0x01.
  - scan_out=1 only while out=0x80.
- LFSR sequence and period, with mode=01 from reset:
  - Sequence -> 0x02, 0x04, 0x08, 0x11, 0x23 on successive cycles.
  - Period: with NUM_PAT=1000, after 255 advances out=0x01 again, and all 255 states are distinct and nonzero.
- Lockup: load=1 with seed_in=0x00, then mode=01, enb=1 -> out=0x01 and lockup=1 for exactly one cycle.
- MISR: load seed_in=0x01, mode=10, data_in=0xFF, one enb -> out=0xFD.
- Terminator, NUM_PAT=255, mode=01, enb held high:
  - After 255 advances, done=1 and out=0x01.
  - Further enb leaves out at 0x01.
  - load seed_in=0x5A -> out=0x5A, done=0, and counting resumes.
- Priority and scan:
  - load=1 with enb=1 -> seed_in is taken.
  - reset=0 with load=1 -> out=SEED.
  - mode=11, scan_in bits 1,0,1,1,0,0,1,0 from out=0x00 -> out=0xB2 after 8 cycles.
